chunked_priority_scanner: RTL and testbench

//  Multi-cycle, parametrised first-set-bit scanner for the FP datapath (mantissa normalise/align).

---
 rtl/fp_scan_pkg.sv | 14 +
 rtl/chunk_prio_enc.sv | 28 ++
 rtl/chunked_priority_scanner.sv | 125 ++++++++++++
 tb/tb_chunked_priority_scanner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_scan_pkg.sv
// Shared types and helpers for the chunked first-set-bit scanner.
package fp_scan_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_RUN,
    SCAN_HOLD
  } scan_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/chunk_prio_enc.sv
// Combinational priority encoder for one chunk: lowest or highest set bit.
module chunk_prio_enc #(
  parameter  int CHUNK_WIDTH = 8,
  localparam int OFF_WIDTH   = (CHUNK_WIDTH > 1) ? $clog2(CHUNK_WIDTH) : 1
) (
  input  logic [CHUNK_WIDTH-1:0] chunk,
  input  logic                   msb_first,
  output logic                   hit,
  output logic [OFF_WIDTH-1:0]   offset
);

  // NOTE: every output of an always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    hit    = |chunk;
    offset = '0;
    if (msb_first) begin
      // Ascending walk: the last set bit seen is the highest one.
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
        if (chunk[i]) offset = OFF_WIDTH'(i);
      end
    end else begin
      for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
        if (chunk[i]) offset = OFF_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/chunked_priority_scanner.sv
// Multi-cycle first-set-bit scanner: one CHUNK_WIDTH slice per cycle, early exit on hit,
// valid/ready on both sides with a single request in flight.
module chunked_priority_scanner
  import fp_scan_pkg::*;
#(
  parameter  int IN_WIDTH    = 27,
  parameter  int CHUNK_WIDTH = 8,
  localparam int IDX_WIDTH   = $clog2(IN_WIDTH),
  localparam int CNT_WIDTH   = $clog2(IN_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_msb_first,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_found,
  output logic [IDX_WIDTH-1:0] out_index,
  output logic [CNT_WIDTH-1:0] out_zero_cnt
);

  localparam int NUM_CHUNKS = ceil_div(IN_WIDTH, CHUNK_WIDTH);
  localparam int PAD_WIDTH  = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int OFF_WIDTH  = (CHUNK_WIDTH > 1) ? $clog2(CHUNK_WIDTH) : 1;
  localparam int JCNT_WIDTH = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  scan_state_t           r_state;
  scan_state_t           w_next_state;
  logic [PAD_WIDTH-1:0]  r_data;
  logic                  r_msb_first;
  logic [JCNT_WIDTH-1:0] r_chunk_cnt;
  logic                  r_found;
  logic [IDX_WIDTH-1:0]  r_index;
  logic [CNT_WIDTH-1:0]  r_zero_cnt;

  logic                  w_accept;
  logic                  w_last;
  logic [JCNT_WIDTH-1:0] w_chunk_sel;
  logic [PAD_WIDTH-1:0]  w_shifted;
  logic [CHUNK_WIDTH-1:0] w_chunk;
  logic                  w_hit;
  logic [OFF_WIDTH-1:0]  w_offset;
  logic [IDX_WIDTH-1:0]  w_hit_index;
  logic [CNT_WIDTH-1:0]  w_hit_zero_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_chunk_cnt == JCNT_WIDTH'(NUM_CHUNKS - 1));

  // Scan step j maps to chunk j (LSB-first) or chunk NUM_CHUNKS-1-j (MSB-first).
  assign w_chunk_sel = r_msb_first ? (JCNT_WIDTH'(NUM_CHUNKS - 1) - r_chunk_cnt) : r_chunk_cnt;
  assign w_shifted   = r_data >> (int'(w_chunk_sel) * CHUNK_WIDTH);
  assign w_chunk     = w_shifted[CHUNK_WIDTH-1:0];

  chunk_prio_enc #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_enc (
    .chunk    (w_chunk),
    .msb_first(r_msb_first),
    .hit      (w_hit),
    .offset   (w_offset)
  );

  // Padding bits are zero, so a hit always lies below IN_WIDTH and fits IDX_WIDTH.
  assign w_hit_index    = IDX_WIDTH'(int'(w_chunk_sel) * CHUNK_WIDTH + int'(w_offset));
  assign w_hit_zero_cnt = r_msb_first ? (CNT_WIDTH'(IN_WIDTH - 1) - CNT_WIDTH'(w_hit_index))
                                      : CNT_WIDTH'(w_hit_index);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= SCAN_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      SCAN_IDLE: if (in_valid)        w_next_state = SCAN_RUN;
      SCAN_RUN:  if (w_hit || w_last) w_next_state = SCAN_HOLD;
      SCAN_HOLD: if (out_ready)       w_next_state = SCAN_IDLE;
      default:                        w_next_state = SCAN_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == SCAN_IDLE);
    out_valid = (r_state == SCAN_HOLD);
  end

  // NOTE: the captured operand is pure datapath; it is always reloaded on accept, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data      <= PAD_WIDTH'(in_data);
      r_msb_first <= in_msb_first;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_chunk_cnt <= '0;
      r_found     <= 1'b0;
      r_index     <= '0;
      r_zero_cnt  <= '0;
    end else if (w_accept) begin
      r_chunk_cnt <= '0;
    end else if (r_state == SCAN_RUN) begin
      r_chunk_cnt <= r_chunk_cnt + 1'b1;
      if (w_hit) begin
        r_found    <= 1'b1;
        r_index    <= w_hit_index;
        r_zero_cnt <= w_hit_zero_cnt;
      end else if (w_last) begin
        r_found    <= 1'b0;
        r_index    <= '1;
        r_zero_cnt <= CNT_WIDTH'(IN_WIDTH);
      end
    end
  end

  assign out_found    = r_found;
  assign out_index    = r_index;
  assign out_zero_cnt = r_zero_cnt;

endmodule

// File: tb/tb_chunked_priority_scanner.sv
// Scoreboard bench for chunked_priority_scanner: directed corner cases plus random requests.
module tb_chunked_priority_scanner;

  localparam int IW = 27;
  localparam int CW = 8;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_msb_first = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_found;
  logic [4:0]    out_index;
  logic [4:0]    out_zero_cnt;

  chunked_priority_scanner #(
    .IN_WIDTH   (IW),
    .CHUNK_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_msb_first(in_msb_first),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_found   (out_found),
    .out_index   (out_index),
    .out_zero_cnt(out_zero_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       found;
    logic [4:0] index;
    logic [4:0] zcnt;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_cur;
  exp_t hold_exp;
  exp_t dropped;
  logic mon_prev = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: find the first set bit in scan direction; latency counts chunks visited.
  function automatic exp_t model(input logic [IW-1:0] d, input logic msb);
    exp_t e;
    int   pos = -1;
    for (int i = 0; i < IW; i++) begin
      if (d[i] && (msb || pos < 0)) pos = i;
    end
    if (pos < 0) begin
      e.found = 1'b0;
      e.index = 5'h1F;
      e.zcnt  = 5'(IW);
      e.lat   = NC;
    end else begin
      e.found = 1'b1;
      e.index = 5'(pos);
      e.zcnt  = msb ? 5'(IW - 1 - pos) : 5'(pos);
      e.lat   = msb ? (NC - pos / CW) : (pos / CW + 1);
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic [IW-1:0] d, input logic msb);
    exp_t e;
    int   k;
    @(negedge clk);
    in_valid     = 1'b1;
    in_data      = d;
    in_msb_first = msb;
    for (k = 0; k < 200 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e     = model(d, msb);
    e.acc = cyc;
    sb.push_back(e);
    in_valid     = 1'b0;
    in_data      = IW'($urandom);
    in_msb_first = ~msb;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300 && (sb.size() != 0 || out_valid); k++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [IW-1:0] rand_data();
    logic [IW-1:0] d;
    case ($urandom_range(0, 3))
      0:       d = IW'($urandom);
      1:       d = IW'(1) << $urandom_range(0, IW - 1);
      2:       d = '0;
      default: d = IW'($urandom & $urandom & $urandom);
    endcase
    return d;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: first cycle of each result is compared against the scoreboard head,
  // then the presented values must stay stable for as long as out_valid is held.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && !mon_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          mon_cur = sb.pop_front();
          check("found", 32'(out_found), 32'(mon_cur.found));
          check("index", 32'(out_index), 32'(mon_cur.index));
          check("zero_cnt", 32'(out_zero_cnt), 32'(mon_cur.zcnt));
          check("latency", 32'(cyc - mon_cur.acc), 32'(mon_cur.lat));
        end
      end else if (out_valid && mon_prev) begin
        check("hold_stable", {out_found, out_index, out_zero_cnt},
              {mon_cur.found, mon_cur.index, mon_cur.zcnt});
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      mon_prev = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_found", 32'(out_found), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_zero_cnt", 32'(out_zero_cnt), 32'd0);
    reset_n = 1'b1;

    send(27'h0000001, 1'b0);
    send(27'h4000000, 1'b1);
    send(27'h4000000, 1'b0);
    send(27'h0000300, 1'b1);
    send(27'h0000000, 1'b0);
    send(27'h0000000, 1'b1);
    send(27'h7FFFFFF, 1'b1);
    send(27'h0000080, 1'b0);
    for (int n = 0; n < 40; n++) send(rand_data(), 1'($urandom_range(0, 1)));
    drain();

    // Consumer stalls for 5 cycles while the producer keeps offering new data.
    ready_mode = 1;
    out_ready  = 1'b0;
    hold_exp   = model(27'h0000300, 1'b1);
    send(27'h0000300, 1'b1);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    check("hold_reached", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid     = 1'b1;
      in_data      = IW'($urandom);
      in_msb_first = 1'($urandom_range(0, 1));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_index", 32'(out_index), 32'(hold_exp.index));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    ready_mode = 0;
    send(27'h4000000, 1'b1);
    drain();

    // Reset in the middle of a 4-chunk scan aborts it; no result may ever appear.
    send(27'h4000000, 1'b0);
    dropped = sb.pop_back();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_found", 32'(out_found), 32'd0);
    check("abort_index", 32'(out_index), 32'd0);
    check("abort_zero_cnt", 32'(out_zero_cnt), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_result", 32'(out_valid), 32'd0);
    end
    send(27'h0000300, 1'b1);
    for (int n = 0; n < 10; n++) send(rand_data(), 1'($urandom_range(0, 1)));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
